// File: rtl/lock_water_ctrl.sv
// rtl/lock_water_ctrl.sv - canal-lock sequencer: equalise, open one gate, transit, open other gate
//
// Ports:
//   clk         in   system clock (divided clock)
//   reset_n     in   synchronous reset, active low
//   tick        in   single-cycle advance strobe for water movement and gate timer
//   req_up      in   boat outside wants to go up (outer -> inner)
//   req_down    in   boat inside wants to go down (inner -> outer)
//   boat_clear  in   pulse: boat has passed the open gate
//   lock_level  out  [7:0] chamber water level
//   outer_gate  out  outer gate open
//   inner_gate  out  inner gate open
//   busy        out  state != IDLE
//   dir         out  latched direction, 0 = up, 1 = down
//   state       out  [2:0] state encoding
module lock_water_ctrl #(
    parameter logic [7:0] OUTER_LEVEL = 8'd0,
    parameter logic [7:0] INNER_LEVEL = 8'd80,
    parameter logic [7:0] RATE        = 8'd4,
    parameter logic [3:0] GATE_TICKS  = 4'd3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       req_up,
    input  logic       req_down,
    input  logic       boat_clear,
    output logic [7:0] lock_level,
    output logic       outer_gate,
    output logic       inner_gate,
    output logic       busy,
    output logic       dir,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EQ_ENTRY   = 3'd1,
        ENTRY_OPEN = 3'd2,
        TRANSIT    = 3'd3,
        EXIT_OPEN  = 3'd4
    } state_t;

    // Held as plain bits so the unused encodings 5..7 are representable and recoverable.
    logic [2:0] state_q;
    logic [7:0] level_q;
    logic       dir_q;
    logic [3:0] timer_q;
    logic       clear_pend;

    logic [7:0] entry_lvl;
    logic [7:0] exit_lvl;
    logic [7:0] target;
    logic [7:0] diff;
    logic [7:0] step_sz;
    logic [7:0] next_level;
    logic       above;
    logic       at_target;
    logic       leave_open;

    // Movement toward the current target: the distance is formed first and the
    // step is clamped to it, so the level lands exactly on target without wrap.
    always_comb begin
        entry_lvl  = dir_q ? INNER_LEVEL : OUTER_LEVEL;
        exit_lvl   = dir_q ? OUTER_LEVEL : INNER_LEVEL;
        target     = (state_q == TRANSIT) ? exit_lvl : entry_lvl;
        above      = level_q > target;
        diff       = above ? (level_q - target) : (target - level_q);
        step_sz    = (diff < RATE) ? diff : RATE;
        next_level = above ? (level_q - step_sz) : (level_q + step_sz);
        at_target  = (level_q == target);
        leave_open = (timer_q >= GATE_TICKS) && clear_pend;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            level_q    <= OUTER_LEVEL;
            dir_q      <= 1'b0;
            timer_q    <= 4'd0;
            clear_pend <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_up) begin
                        dir_q   <= 1'b0;
                        state_q <= EQ_ENTRY;
                    end else if (req_down) begin
                        dir_q   <= 1'b1;
                        state_q <= EQ_ENTRY;
                    end
                end
                EQ_ENTRY, TRANSIT: begin
                    // Level check uses the registered value, so an equal level exits without a tick.
                    if (at_target) begin
                        state_q    <= (state_q == EQ_ENTRY) ? ENTRY_OPEN : EXIT_OPEN;
                        timer_q    <= 4'd0;
                        clear_pend <= 1'b0;
                    end else if (tick) begin
                        level_q <= next_level;
                    end
                end
                ENTRY_OPEN, EXIT_OPEN: begin
                    if (leave_open) begin
                        state_q    <= (state_q == ENTRY_OPEN) ? TRANSIT : IDLE;
                        timer_q    <= 4'd0;
                        clear_pend <= 1'b0;
                    end else begin
                        if (tick && (timer_q < GATE_TICKS))
                            timer_q <= timer_q + 4'd1;
                        // An early clear is remembered until the gate minimum has elapsed.
                        if (boat_clear)
                            clear_pend <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lock_level = level_q;
    assign dir        = dir_q;
    assign state      = state_q;
    assign busy       = (state_q != IDLE);
    assign outer_gate = ((state_q == ENTRY_OPEN) && !dir_q) || ((state_q == EXIT_OPEN) && dir_q);
    assign inner_gate = ((state_q == ENTRY_OPEN) && dir_q) || ((state_q == EXIT_OPEN) && !dir_q);

endmodule

// File: tb/tb_lock_water_ctrl.sv
// tb/tb_lock_water_ctrl.sv - directed vector bench for lock_water_ctrl
module tb_lock_water_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       req_up = 1'b0;
    logic       req_down = 1'b0;
    logic       boat_clear = 1'b0;
    logic       req_up7 = 1'b0;
    logic       boat_clear7 = 1'b0;

    logic [7:0] lock_level, lock_level7;
    logic       outer_gate, inner_gate, busy, dir;
    logic       outer_gate7, inner_gate7, busy7, dir7;
    logic [2:0] state, state7;

    int n_vec = 0;
    int n_bad = 0;
    int gate_viol = 0;

    always #5 clk = ~clk;

    lock_water_ctrl dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .req_up(req_up), .req_down(req_down),
        .boat_clear(boat_clear), .lock_level(lock_level), .outer_gate(outer_gate),
        .inner_gate(inner_gate), .busy(busy), .dir(dir), .state(state)
    );

    lock_water_ctrl #(.RATE(8'd7)) dut7 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .req_up(req_up7), .req_down(1'b0),
        .boat_clear(boat_clear7), .lock_level(lock_level7), .outer_gate(outer_gate7),
        .inner_gate(inner_gate7), .busy(busy7), .dir(dir7), .state(state7)
    );

    // Safety properties watched on every cycle for both instances.
    always @(negedge clk) begin
        if (outer_gate && inner_gate) gate_viol++;
        if (outer_gate7 && inner_gate7) gate_viol++;
        if (outer_gate && lock_level != 8'd0) gate_viol++;
        if (inner_gate && lock_level != 8'd80) gate_viol++;
        if (outer_gate7 && lock_level7 != 8'd0) gate_viol++;
        if (inner_gate7 && lock_level7 != 8'd80) gate_viol++;
    end

    typedef struct {
        logic       rn, ru, rd, t, bc;
        logic [2:0] st;
        logic [7:0] lvl;
        logic       og, ig, bz, dr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int st, input int lvl, input int og,
                           input int ig, input int bz, input int dr);
        chk({name, ".state"}, int'(state), st);
        chk({name, ".level"}, int'(lock_level), lvl);
        chk({name, ".outer"}, int'(outer_gate), og);
        chk({name, ".inner"}, int'(inner_gate), ig);
        chk({name, ".busy"}, int'(busy), bz);
        chk({name, ".dir"}, int'(dir), dr);
    endtask

    // Drive one cycle of inputs at the falling edge, sample just after the rising edge.
    task automatic cyc(input logic rn, input logic ru, input logic rd, input logic t,
                       input logic bc, input logic ru7, input logic bc7);
        @(negedge clk);
        reset_n = rn; req_up = ru; req_down = rd; tick = t; boat_clear = bc;
        req_up7 = ru7; boat_clear7 = bc7;
        @(posedge clk);
        #1;
    endtask

    task automatic tk();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //          rn    ru    rd    t     bc    st    lvl    og    ig    bz    dr
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd8, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'd8, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset, up request, entry gate with early clear, start of fill.
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].rn, vecs[i].ru, vecs[i].rd, vecs[i].t, vecs[i].bc, 1'b0, 1'b0);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].lvl), int'(vecs[i].og),
                    int'(vecs[i].ig), int'(vecs[i].bz), int'(vecs[i].dr));
        end
        chk("reset.dut7_level", int'(lock_level7), 0);

        // Finish the fill 8 -> 80 in steps of 4.
        for (int k = 3; k <= 20; k++) begin
            tk();
            chk($sformatf("fill.level%0d", k), int'(lock_level), 4 * k);
            chk($sformatf("fill.state%0d", k), int'(state), 3);
        end
        idle();
        chk_all("exit_open", 4, 80, 0, 1, 1, 0);
        // Clear given during TRANSIT must not have been carried into EXIT_OPEN.
        tk(); tk(); tk(); idle();
        chk("exit_no_pend.state", int'(state), 4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("exit_clear.state", int'(state), 4);
        idle();
        chk_all("back_idle", 0, 80, 0, 0, 0, 0);

        // RATE=7 instance: fill 0 -> 80 ends with a short step of 3.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("r7.eq_entry", int'(state7), 1);
        idle();
        chk("r7.entry_open", int'(state7), 2);
        chk("r7.outer_gate", int'(outer_gate7), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tk(); tk(); tk(); idle();
        chk("r7.transit", int'(state7), 3);
        for (int k = 1; k <= 11; k++) begin
            tk();
            chk($sformatf("r7.level%0d", k), int'(lock_level7), 7 * k);
        end
        tk();
        chk("r7.level_last", int'(lock_level7), 80);
        idle();
        chk("r7.exit_open", int'(state7), 4);
        chk("r7.inner_gate", int'(inner_gate7), 1);
        chk("r7.main_unmoved", int'(lock_level), 80);

        // Both requests at level 80: up wins, chamber drains to outer level.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("both_req", 1, 80, 0, 0, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            tk();
            chk($sformatf("drain.level%0d", k), int'(lock_level), 80 - 4 * k);
            chk($sformatf("drain.outer%0d", k), int'(outer_gate), 0);
        end
        idle();
        chk_all("drain_open", 2, 0, 1, 0, 1, 0);

        // Reset in the middle of TRANSIT at level 40.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tk(); tk(); tk(); idle();
        chk("mid.transit", int'(state), 3);
        for (int k = 1; k <= 10; k++) tk();
        chk("mid.level40", int'(lock_level), 40);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("mid_reset", 0, 0, 0, 0, 0, 0);

        // boat_clear in IDLE is not remembered.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_clear.state", int'(state), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        tk(); tk(); tk(); idle();
        chk("idle_clear.held", int'(state), 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("idle_clear.release", int'(state), 3);

        // Down request from level 0: no tick means no movement.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("down_req", 1, 0, 0, 0, 1, 1);
        idle(); idle(); idle();
        chk("frozen.level", int'(lock_level), 0);
        chk("frozen.state", int'(state), 1);
        tk();
        chk("down.step", int'(lock_level), 4);
        idle();
        chk("down.hold", int'(lock_level), 4);

        // Illegal encoding recovers to IDLE on the next edge.
        @(negedge clk);
        force dut.state_q = 3'd6;
        #1;
        chk("illegal.state", int'(state), 6);
        chk("illegal.busy", int'(busy), 1);
        #1;
        release dut.state_q;
        @(posedge clk);
        #1;
        chk("recover.state", int'(state), 0);
        chk("recover.busy", int'(busy), 0);

        chk("gate_monitor", gate_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
